// File: rtl/cannon_shell.sv
// cannon_shell: ballistic shell stage; latches the launch state on fire and steps a gravity trajectory per tick.
// Optional macro SHELL_WIND_EN adds a signed wind input that nudges vx after every position step.
//
// state | meaning
// IDLE  | waiting for fire, shell position holds last value
// CALC  | derive vx/vy from power and angle LUT
// FLY   | waiting for tick, then step position and gravity
// CHECK | resolve out-of-bounds / hit / terrain / timeout
module cannon_shell #(
    parameter int unsigned GRAVITY   = 4,
    parameter logic [17:0] HIT_R     = 18'h20,
    parameter logic [17:0] BOARD_X   = 18'h20000,
    parameter logic [17:0] BOARD_Y   = 18'h18000,
    parameter int unsigned MAX_TICKS = 1023
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                tick,
    input  logic                fire,
    input  logic [17:0]         launch_x,
    input  logic [17:0]         launch_y,
    input  logic                direction,
    input  logic [7:0]          angle,
    input  logic [7:0]          power,
    input  logic [17:0]         target_x,
    input  logic [17:0]         target_y,
    input  logic                terrain_solid,
`ifdef SHELL_WIND_EN
    input  logic signed [4:0]   wind,
`endif
    output logic [17:0]         shell_x,
    output logic [17:0]         shell_y,
    output logic                active,
    output logic                busy,
    output logic                hit,
    output logic                done
);

    localparam int CW = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {IDLE, CALC, FLY, CHECK} state_t;

    state_t             state_q, state_d;
    logic [17:0]        shell_x_q, shell_x_d, shell_y_q, shell_y_d;
    logic               dir_q, dir_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         pow_q, pow_d;
    logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               oob_q, oob_d, hit_q, hit_d, done_q, done_d;

    logic [8:0]         vx_mag, vy_mag;
    logic signed [19:0] nx_c, ny_c;
    logic signed [11:0] vy_sub;
    logic [17:0]        dx_c, dy_c;
    logic               unused_angle_lsb;

    assign unused_angle_lsb = ^angle[3:0];

    function automatic logic [8:0] cos_lut(input logic [3:0] i);
        case (i)
            4'd0:    cos_lut = 9'd256;
            4'd1:    cos_lut = 9'd252;
            4'd2:    cos_lut = 9'd241;
            4'd3:    cos_lut = 9'd222;
            4'd4:    cos_lut = 9'd196;
            4'd5:    cos_lut = 9'd165;
            4'd6:    cos_lut = 9'd128;
            4'd7:    cos_lut = 9'd88;
            4'd8:    cos_lut = 9'd44;
            default: cos_lut = 9'd0;
        endcase
    endfunction

    // sin table is the cos table read backwards
    assign vx_mag = 9'(({9'b0, pow_q} * {8'b0, cos_lut(idx_q)}) >> 8);
    assign vy_mag = 9'(({9'b0, pow_q} * {8'b0, cos_lut(4'd9 - idx_q)}) >> 8);

    assign nx_c   = $signed({2'b00, shell_x_q}) + $signed({{9{vx_q[10]}}, vx_q});
    assign ny_c   = $signed({2'b00, shell_y_q}) - $signed({{9{vy_q[10]}}, vy_q});
    assign vy_sub = $signed({vy_q[10], vy_q}) - $signed(12'(GRAVITY));
    assign dx_c   = (shell_x_q >= target_x) ? shell_x_q - target_x : target_x - shell_x_q;
    assign dy_c   = (shell_y_q >= target_y) ? shell_y_q - target_y : target_y - shell_y_q;

`ifdef SHELL_WIND_EN
    logic signed [11:0] vx_sum;
    assign vx_sum = $signed({vx_q[10], vx_q}) + $signed({{7{wind[4]}}, wind});
`endif

    always_comb begin
        state_d   = state_q;
        shell_x_d = shell_x_q;
        shell_y_d = shell_y_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        pow_d     = pow_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        cnt_d     = cnt_q;
        oob_d     = oob_q;
        hit_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    shell_x_d = launch_x;
                    shell_y_d = launch_y;
                    dir_d     = direction;
                    idx_d     = (angle[7:4] > 4'd9) ? 4'd9 : angle[7:4];
                    pow_d     = power;
                    state_d   = CALC;
                end
            end
            CALC: begin
                vx_d    = dir_q ? $signed({2'b00, vx_mag}) : -$signed({2'b00, vx_mag});
                vy_d    = $signed({2'b00, vy_mag});
                cnt_d   = '0;
                state_d = FLY;
            end
            FLY: begin
                if (tick) begin
                    oob_d = nx_c[19] || (nx_c > $signed({2'b00, BOARD_X}))
                         || ny_c[19] || (ny_c > $signed({2'b00, BOARD_Y}));
                    if (!oob_d) begin
                        shell_x_d = nx_c[17:0];
                        shell_y_d = ny_c[17:0];
                    end
                    vy_d = (vy_sub < -12'sd1024) ? 11'sh400 : vy_sub[10:0];
`ifdef SHELL_WIND_EN
                    if (vx_sum > 12'sd1023)
                        vx_d = 11'sh3FF;
                    else if (vx_sum < -12'sd1024)
                        vx_d = 11'sh400;
                    else
                        vx_d = vx_sum[10:0];
`endif
                    cnt_d   = cnt_q + CW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (oob_q) begin
                    done_d = 1'b1;
                end else if (dx_c <= HIT_R && dy_c <= HIT_R) begin
                    hit_d  = 1'b1;
                    done_d = 1'b1;
                end else if (terrain_solid || cnt_q == CW'(MAX_TICKS)) begin
                    done_d = 1'b1;
                end else begin
                    state_d = FLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            shell_x_q <= '0;
            shell_y_q <= '0;
            dir_q     <= 1'b0;
            idx_q     <= '0;
            pow_q     <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            cnt_q     <= '0;
            oob_q     <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shell_x_q <= shell_x_d;
            shell_y_q <= shell_y_d;
            dir_q     <= dir_d;
            idx_q     <= idx_d;
            pow_q     <= pow_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            cnt_q     <= cnt_d;
            oob_q     <= oob_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
        end
    end

    assign shell_x = shell_x_q;
    assign shell_y = shell_y_q;
    assign active  = (state_q == FLY) || (state_q == CHECK);
    assign busy    = (state_q != IDLE);
    assign hit     = hit_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cannon_shell.sv
// Directed bench for cannon_shell: one task per scenario, hand-computed trajectories.
module tb_cannon_shell;

    logic        clock = 1'b0;
    logic        rst = 1'b1, tick = 1'b0, fire = 1'b0, direction = 1'b0, terrain_solid = 1'b0;
    logic [17:0] launch_x = '0, launch_y = '0, target_x = '0, target_y = '0;
    logic [7:0]  angle = '0, power = '0;
    logic [17:0] shell_x, shell_y, shell_x_to, shell_y_to;
    logic        active, busy, hit, done, active_to, busy_to, hit_to, done_to;
    int          checks = 0, errors = 0;
`ifdef SHELL_WIND_EN
    logic signed [4:0] wind = '0;
`endif

    always #5 clock = ~clock;

    cannon_shell dut (
        .clock(clock), .rst(rst), .tick(tick), .fire(fire),
        .launch_x(launch_x), .launch_y(launch_y), .direction(direction),
        .angle(angle), .power(power), .target_x(target_x), .target_y(target_y),
        .terrain_solid(terrain_solid),
`ifdef SHELL_WIND_EN
        .wind(wind),
`endif
        .shell_x(shell_x), .shell_y(shell_y), .active(active), .busy(busy),
        .hit(hit), .done(done)
    );

    cannon_shell #(.MAX_TICKS(4)) dut_to (
        .clock(clock), .rst(rst), .tick(tick), .fire(fire),
        .launch_x(launch_x), .launch_y(launch_y), .direction(direction),
        .angle(angle), .power(power), .target_x(target_x), .target_y(target_y),
        .terrain_solid(terrain_solid),
`ifdef SHELL_WIND_EN
        .wind(wind),
`endif
        .shell_x(shell_x_to), .shell_y(shell_y_to), .active(active_to), .busy(busy_to),
        .hit(hit_to), .done(done_to)
    );

    task automatic do_reset();
        @(negedge clock); rst = 1'b1;
        @(negedge clock);
        @(negedge clock); rst = 1'b0;
    endtask

    task automatic launch(input logic [17:0] x, input logic [17:0] y, input logic dir,
                          input logic [7:0] ang, input logic [7:0] pow);
        @(negedge clock);
        launch_x = x; launch_y = y; direction = dir; angle = ang; power = pow; fire = 1'b1;
        @(negedge clock); fire = 1'b0;
    endtask

    // returns at the negedge after CHECK has resolved
    task automatic do_tick();
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({shell_x, shell_y} !== 36'h0) begin errors++; $display("FAIL reset_pos: got %h/%h expected 0/0", shell_x, shell_y); end
        checks++; if ({active, busy, hit, done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {active, busy, hit, done}); end
    endtask

    task automatic test_level_shot();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h1000, 18'h8000, 1'b1, 8'h00, 8'h80);
        checks++; if ({active, busy} !== 2'b01) begin errors++; $display("FAIL calc_flags: got %b expected 01", {active, busy}); end
        tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        checks++; if (shell_x !== 18'h1000 || active !== 1'b1) begin errors++; $display("FAIL calc_tick_dropped: got %h/%b expected 01000/1", shell_x, active); end
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1080, 18'h8000}) begin errors++; $display("FAIL level_t1: got %h/%h expected 01080/08000", shell_x, shell_y); end
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1100, 18'h8004}) begin errors++; $display("FAIL level_t2: got %h/%h expected 01100/08004", shell_x, shell_y); end
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1180, 18'h800C}) begin errors++; $display("FAIL level_t3: got %h/%h expected 01180/0800c", shell_x, shell_y); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL level_flying: got done=%b busy=%b expected 0/1", done, busy); end
    endtask

    task automatic test_vertical_hit();
        do_reset();
        target_x = 18'h2000; target_y = 18'h8000;
        launch(18'h2000, 18'h8000, 1'b1, 8'h90, 8'h40);
        for (int n = 1; n <= 33; n++) begin
            do_tick();
            if (n == 1) begin
                checks++; if (shell_y !== 18'h7FC0) begin errors++; $display("FAIL vert_t1: got %h expected 07fc0", shell_y); end
            end
            if (n < 33) begin
                checks++; if ({hit, done} !== 2'b00) begin errors++; $display("FAIL vert_early_end t%0d: got %b expected 00", n, {hit, done}); end
            end
            if (n == 32) begin
                checks++; if ({shell_x, shell_y} !== {18'h2000, 18'h7FC0}) begin errors++; $display("FAIL vert_t32: got %h/%h expected 02000/07fc0", shell_x, shell_y); end
            end
        end
        checks++; if (shell_y !== 18'h8000) begin errors++; $display("FAIL vert_t33_y: got %h expected 08000", shell_y); end
        checks++; if ({hit, done, busy} !== 3'b110) begin errors++; $display("FAIL vert_hit: got %b expected 110", {hit, done, busy}); end
        @(negedge clock);
        checks++; if ({hit, done} !== 2'b00) begin errors++; $display("FAIL vert_pulse_width: got %b expected 00", {hit, done}); end
        checks++; if (shell_y !== 18'h8000) begin errors++; $display("FAIL vert_hold: got %h expected 08000", shell_y); end
    endtask

    task automatic test_left_oob();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h0040, 18'h8000, 1'b0, 8'h00, 8'h80);
        do_tick();
        checks++; if ({done, hit, busy} !== 3'b100) begin errors++; $display("FAIL oob_flags: got %b expected 100", {done, hit, busy}); end
        checks++; if (shell_x !== 18'h0040) begin errors++; $display("FAIL oob_x_hold: got %h expected 00040", shell_x); end
    endtask

    task automatic test_terrain();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h1000, 18'h8000, 1'b1, 8'h00, 8'h80);
        repeat (4) do_tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL terrain_early: got %b expected 0", done); end
        terrain_solid = 1'b1;
        do_tick();
        terrain_solid = 1'b0;
        checks++; if ({done, hit, busy} !== 3'b100) begin errors++; $display("FAIL terrain_end: got %b expected 100", {done, hit, busy}); end
        checks++; if (shell_x !== 18'h1280) begin errors++; $display("FAIL terrain_x: got %h expected 01280", shell_x); end
    endtask

    task automatic test_timeout();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h1000, 18'h8000, 1'b1, 8'h00, 8'h80);
        repeat (3) do_tick();
        checks++; if (done_to !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", done_to); end
        do_tick();
        checks++; if ({done_to, hit_to, busy_to} !== 3'b100) begin errors++; $display("FAIL timeout_end: got %b expected 100", {done_to, hit_to, busy_to}); end
        checks++; if (shell_x_to !== 18'h1200) begin errors++; $display("FAIL timeout_x: got %h expected 01200", shell_x_to); end
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL default_no_timeout: got %b expected 01", {done, busy}); end
    endtask

    task automatic test_power_zero_and_clamp();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h1000, 18'h0100, 1'b1, 8'h40, 8'h00);
        do_tick();
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1000, 18'h0104}) begin errors++; $display("FAIL power0: got %h/%h expected 01000/00104", shell_x, shell_y); end
        do_reset();
        launch(18'h1000, 18'h8000, 1'b1, 8'hF0, 8'h40);
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1000, 18'h7FC0}) begin errors++; $display("FAIL angle_clamp: got %h/%h expected 01000/07fc0", shell_x, shell_y); end
    endtask

    task automatic test_busy_and_reset();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        launch(18'h1000, 18'h8000, 1'b1, 8'h00, 8'h80);
        do_tick();
        launch(18'h5000, 18'h0100, 1'b0, 8'h90, 8'hFF);
        checks++; if (shell_x !== 18'h1080 || busy !== 1'b1) begin errors++; $display("FAIL busy_fire_ignored: got %h/%b expected 01080/1", shell_x, busy); end
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1100, 18'h8004}) begin errors++; $display("FAIL busy_t2: got %h/%h expected 01100/08004", shell_x, shell_y); end
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h1180, 18'h800C}) begin errors++; $display("FAIL busy_t3: got %h/%h expected 01180/0800c", shell_x, shell_y); end
        @(negedge clock); rst = 1'b1;
        @(negedge clock); rst = 1'b0;
        checks++; if ({shell_x, shell_y, active, busy, hit, done} !== 40'h0) begin errors++; $display("FAIL midflight_reset: got %h/%h %b expected 0/0 0000", shell_x, shell_y, {active, busy, hit, done}); end
        launch(18'h3000, 18'h4000, 1'b1, 8'h00, 8'h80);
        do_tick();
        checks++; if ({shell_x, shell_y} !== {18'h3080, 18'h4000}) begin errors++; $display("FAIL post_reset_launch: got %h/%h expected 03080/04000", shell_x, shell_y); end
    endtask

`ifdef SHELL_WIND_EN
    task automatic test_wind();
        do_reset();
        target_x = 18'h30000; target_y = 18'h0;
        wind = 5'sd2;
        launch(18'h1000, 18'h8000, 1'b1, 8'h00, 8'h80);
        do_tick();
        checks++; if (shell_x !== 18'h1080) begin errors++; $display("FAIL wind_t1: got %h expected 01080", shell_x); end
        do_tick();
        checks++; if (shell_x !== 18'h1102) begin errors++; $display("FAIL wind_t2: got %h expected 01102", shell_x); end
        do_tick();
        checks++; if (shell_x !== 18'h1186) begin errors++; $display("FAIL wind_t3: got %h expected 01186", shell_x); end
        wind = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_level_shot();
        test_vertical_hit();
        test_left_oob();
        test_terrain();
        test_timeout();
        test_power_zero_and_clamp();
        test_busy_and_reset();
`ifdef SHELL_WIND_EN
        test_wind();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cannon_shell.md
Name: cannon_shell

Overview:
Ballistic projectile stage downstream of the player block. On a fire strobe it latches the firing player's position, facing direction, angle and power, then steps a gravity trajectory on each slow movement tick. It reports shell position for drawing and terrain lookup, and raises a one-cycle hit pulse that drives the opponent player's hit input.

Parameters:
GRAVITY, 4, vertical speed decrement per tick (units/tick²)
HIT_R, 18'h20, hit window half-width on each axis
BOARD_X, 18'h20000, largest legal x
BOARD_Y, 18'h18000, largest legal y (y grows downward)
MAX_TICKS, 1023, flight timeout in ticks

Ports:
clock  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle movement strobe (slow time base)
fire  in  1  one-cycle launch request
launch_x  in  18  firing player x
launch_y  in  18  firing player y
direction  in  1  1 = right (+x), 0 = left (−x)
angle  in  8  firing angle, legal 8'h00..8'h90; index = angle[7:4]
power  in  8  launch power 0..255
target_x  in  18  opponent x
target_y  in  18  opponent y
terrain_solid  in  1  external map lookup at current shell_x/shell_y
shell_x  out  18  shell x
shell_y  out  18  shell y
active  out  1  shell in flight (FLY or CHECK)
busy  out  1  not IDLE
hit  out  1  one-cycle pulse, target struck
done  out  1  one-cycle pulse, flight ended (hit or miss)

Behaviour:
- Reset (sync, high, wins over everything): state IDLE; shell_x=0, shell_y=0, active=0, busy=0, hit=0, done=0; velocities and tick counter 0.
- States: IDLE, CALC, FLY, CHECK.
- IDLE: fire=1 -> latch launch_x/y into shell_x/y; latch direction, angle[7:4], power; go CALC. No other input has effect.
- CALC (1 cycle): idx = min(angle[7:4], 9). LUT cos ×256 = 256,252,241,222,196,165,128,88,44,0; sin = reverse order. vx = (power × cos[idx]) >> 8, negated when direction=0 (signed 11-bit). vy = (power × sin[idx]) >> 8 (signed 11-bit, up positive). Clear tick counter; go FLY. A tick arriving during CALC is dropped.
- FLY: on tick, using the current velocities: nx = shell_x + vx, ny = shell_y − vy, computed in 20-bit signed. Register oob = (nx<0) | (nx>BOARD_X) | (ny<0) | (ny>BOARD_Y). Store nx/ny into shell_x/shell_y truncated to 18 bits, only when oob=0. Then vy = vy − GRAVITY, saturating at −1024. Increment tick counter; go CHECK.
- CHECK (1 cycle, priority order):
  1. oob -> done.
  2. |shell_x−target_x| ≤ HIT_R and |shell_y−target_y| ≤ HIT_R -> hit=1 and done=1.
  3. terrain_solid=1 -> done.
  4. tick counter = MAX_TICKS -> done.
  5. Otherwise return to FLY.
  Any done -> IDLE.
- terrain_solid is valid in CHECK, one cycle after the shell_x/shell_y update.
- hit and done are registered, one clock wide, asserted in the cycle after CHECK. hit is never asserted without done.
- fire while busy=1 is ignored; fire is accepted in the same cycle done pulses (state already IDLE).
- active=1 in FLY and CHECK; busy=1 in CALC, FLY and CHECK.
- shell_x/shell_y hold their last value after a flight until the next fire.
- Power 0 -> vx=vy=0; the shell drops under gravity only.
- Angle above 8'h90 clamps to index 9.

Optional Feature:
Macro SHELL_WIND_EN. When defined: extra input port wind (5-bit signed, +x positive). In FLY, after the position update, vx = vx + wind, saturating to −1024..1023. When undefined: no wind port; vx is constant for the whole flight.

Test Plan:
- Level shot: launch (0x1000,0x8000), direction=1, angle=0x00, power=0x80, target far, terrain=0. After tick1 shell=(0x1080,0x8000); after tick2 (0x1100,0x8004); after tick3 (0x1180,0x800C).
- Vertical hit: angle=0x90, power=0x40, target=launch point=(0x2000,0x8000). After tick1 y=0x7FC0; after tick32 y=0x7FC0 with no hit; after tick33 y=0x8000, then hit=1 and done=1 for one cycle.
- Left out-of-bounds: launch x=0x40, direction=0, angle=0, power=0x80. After first tick+CHECK: done=1, hit=0, shell_x stays 0x40, busy=0.
- Terrain and timeout: terrain_solid forced 1 at tick 5 -> done at that CHECK, hit=0. Separate run with MAX_TICKS=4 and no obstacle -> done after tick 4.
- Busy and reset: fire pulsed again mid-flight -> trajectory unchanged. rst asserted mid-flight -> next cycle all outputs 0, state IDLE; a fire after reset launches normally.
- SHELL_WIND_EN: wind=+2, level shot as above, power 0x80 -> x steps of 0x80, 0x82, 0x84.
